// File: rtl/mac_bank.sv
// mac_bank: bank of NUM_ACC fixed-point multiply-accumulate registers behind
// a Nios II multi-cycle custom-instruction port. A radix-2 shift-add
// multiplier works on operand magnitudes and applies the sign at the end.
//
// Optional feature macro: MAC_BANK_SAT_EN
//   defined   - MAC/MSUB saturate at the ACC_W signed limits, READ/RDCLR
//               clamp to the DATA_W signed range.
//   undefined - MAC/MSUB wrap modulo 2^ACC_W, READ/RDCLR return low bits.
//
// Handshake: start is taken only in IDLE with clk_en=1; operands and n are
// latched on that edge. done is a one-cycle (clk_en-qualified) pulse and
// result is valid from the same edge, held until the next done. While
// clk_en=0 every register, including done and result, holds its value.
module mac_bank #(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int NUM_ACC = 4,
    parameter int GUARD_W = 8
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] dataa,
    input  logic [DATA_W-1:0] datab,
    input  logic [4:0]        n,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    localparam int ACC_W  = DATA_W + GUARD_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam int EXT_W  = PROD_W + 1 + ACC_W;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_MAC   = 3'b001;
    localparam logic [2:0] OP_READ  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_RDCLR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // state is the FSM observation point for checkers bound to this block
    state_t state;
    state_t state_nxt;

    logic [2:0]        op_q;
    logic [1:0]        idx_q;
    logic              neg_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] mcand_q;
    logic [PROD_W-1:0] prod_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ACC_W-1:0]  sum_q;
    logic [ACC_W-1:0]  acc [NUM_ACC];

    logic              idx_ok;
    logic [ACC_W-1:0]  acc_sel;
    logic [PROD_W:0]   prod_s;
    logic [EXT_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  p_acc;
    logic [ACC_W-1:0]  sum_nxt;
    logic [DATA_W:0]   step_sum;
    logic              wr_en;
    logic [ACC_W-1:0]  wr_val;
    logic [DATA_W-1:0] res_nxt;

    // Accumulator to DATA_W read-out: plain truncation or signed clamp.
    function automatic logic [DATA_W-1:0] rd(input logic [ACC_W-1:0] v);
`ifdef MAC_BANK_SAT_EN
        logic [GUARD_W:0] top;
        top = v[ACC_W-1:DATA_W-1];
        if (&top || ~|top)
            return v[DATA_W-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    // Select the addressed accumulator; out-of-range indices read as zero.
    always_comb begin
        acc_sel = '0;
        idx_ok  = ({1'b0, idx_q} < 3'(NUM_ACC));
        for (int i = 0; i < NUM_ACC; i++) begin
            if (idx_q == 2'(i))
                acc_sel = acc[i];
        end
    end

    // Signed product, arithmetic shift (floor), add/sub with optional saturation.
    always_comb begin
        step_sum = {1'b0, prod_q[PROD_W-1:DATA_W]}
                 + {1'b0, ({DATA_W{prod_q[0]}} & mcand_q)};
        prod_s   = neg_q ? (~{1'b0, prod_q} + 1'b1) : {1'b0, prod_q};
        prod_ext = {{ACC_W{prod_s[PROD_W]}}, prod_s};
        p_acc    = ACC_W'($signed(prod_ext) >>> FRAC_W);
`ifdef MAC_BANK_SAT_EN
        begin
            logic [ACC_W:0] sum_w;
            if (op_q == OP_MSUB)
                sum_w = {acc_sel[ACC_W-1], acc_sel} - {p_acc[ACC_W-1], p_acc};
            else
                sum_w = {acc_sel[ACC_W-1], acc_sel} + {p_acc[ACC_W-1], p_acc};
            if (sum_w[ACC_W] != sum_w[ACC_W-1])
                sum_nxt = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
            else
                sum_nxt = sum_w[ACC_W-1:0];
        end
`else
        if (op_q == OP_MSUB)
            sum_nxt = acc_sel - p_acc;
        else
            sum_nxt = acc_sel + p_acc;
`endif
    end

    // Commit decode for the FIN cycle: accumulator write and new result.
    always_comb begin
        wr_en   = 1'b0;
        wr_val  = '0;
        res_nxt = '0;
        case (op_q)
            OP_CLEAR: begin
                wr_en = 1'b1;
            end
            OP_MAC, OP_MSUB: begin
                wr_en   = 1'b1;
                wr_val  = sum_q;
                res_nxt = rd(sum_q);
            end
            OP_READ: begin
                res_nxt = rd(acc_sel);
            end
            OP_LOAD: begin
                wr_en   = 1'b1;
                wr_val  = {{GUARD_W{a_q[DATA_W-1]}}, a_q};
                res_nxt = a_q;
            end
            OP_RDCLR: begin
                wr_en   = 1'b1;
                res_nxt = rd(acc_sel);
            end
            default: begin
                res_nxt = '0;
            end
        endcase
        if (!idx_ok) begin
            wr_en   = 1'b0;
            res_nxt = '0;
        end
    end

    // Next-state logic: multiplier ops take the long path, others go to FIN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (n[2:0] == OP_MAC || n[2:0] == OP_MSUB)
                        state_nxt = S_MUL;
                    else
                        state_nxt = S_FIN;
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_W'(DATA_W - 1))
                    state_nxt = S_ACC;
            end
            S_ACC:   state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, stalled by clk_en.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)
            state <= S_IDLE;
        else if (clk_en)
            state <= state_nxt;
    end

    // Operand latch, shift-add multiplier iterations and staged sum.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            op_q    <= '0;
            idx_q   <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= n[2:0];
                        idx_q   <= n[4:3];
                        neg_q   <= dataa[DATA_W-1] ^ datab[DATA_W-1];
                        a_q     <= dataa;
                        mcand_q <= dataa[DATA_W-1] ? (~dataa + 1'b1) : dataa;
                        prod_q  <= {{DATA_W{1'b0}},
                                    (datab[DATA_W-1] ? (~datab + 1'b1) : datab)};
                        cnt_q   <= '0;
                    end
                end
                S_MUL: begin
                    prod_q <= {step_sum, prod_q[DATA_W-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                end
                S_ACC: begin
                    sum_q <= sum_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    // Accumulator bank: only the addressed entry is written, in the FIN cycle.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < NUM_ACC; i++)
                acc[i] <= '0;
        end else if (clk_en && state == S_FIN && wr_en) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (idx_q == 2'(i))
                    acc[i] <= wr_val;
            end
        end
    end

    // Result and done update together on the edge that leaves FIN.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            result <= '0;
            done   <= 1'b0;
        end else if (clk_en) begin
            done <= (state == S_FIN);
            if (state == S_FIN)
                result <= res_nxt;
        end
    end

endmodule
